serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles each serial bit is held on D; legal range 1..255.
REQ-002 SHALL have parameter DATA_W, default 8, meaning payload bits per frame; legal range 1..16.
REQ-003 SHALL have parameter PARITY_EN, default 0, meaning 1 inserts an even-parity bit after the payload and 0 omits it.
REQ-004 SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port Data, input, DATA_W bits: the parallel word to transmit.
REQ-007 SHALL have port Load, input, 1 bit: request to send Data.
REQ-008 SHALL have port Ready, output, 1 bit: high when a Load will be accepted.
REQ-009 SHALL have port D, output, 1 bit: the serial line, registered, idle-high.
REQ-010 SHALL have port Busy, output, 1 bit: high while a frame is on D.
REQ-011 SHALL have port Done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-012 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP; PARITY is visited only when PARITY_EN=1.
REQ-013 SHALL set the frame length N = 1 + DATA_W + PARITY_EN + 1 bits; total frame time is N*CLKS_PER_BIT cycles.
REQ-014 SHALL accept a frame on rising edge k when Load=1 and Ready=1; Data is captured into an internal shift register at that edge.
REQ-015 SHALL ignore Load while Ready=0; no queuing, no error flag, and the frame in progress is unaffected.
REQ-016 SHALL leave D unaffected by changes to Data after edge k.
REQ-017 SHALL make Ready=1 only in IDLE, and Busy equal to the inverse of Ready at all times.
REQ-018 SHALL, after edge k, drive D=0 (start bit) for exactly CLKS_PER_BIT cycles.
REQ-019 SHALL then drive the payload LSB first, each bit for exactly CLKS_PER_BIT cycles.
REQ-020 SHALL, when PARITY_EN=1, drive the XOR of all captured payload bits (even parity) for CLKS_PER_BIT cycles.
REQ-021 SHALL drive the stop bit D=1 for CLKS_PER_BIT cycles.
REQ-022 SHALL, at edge k+N*CLKS_PER_BIT, enter IDLE: Ready=1, Busy=0, D=1, and Done=1 for exactly the following cycle.
REQ-023 SHALL accept a back-to-back frame no earlier than edge k+N*CLKS_PER_BIT+1, giving one idle-high cycle between frames.
REQ-024 SHALL use a bit-period counter wide enough for CLKS_PER_BIT-1 that reloads at each bit boundary; with CLKS_PER_BIT=1 each bit lasts one cycle and there are no skipped or doubled bits.
REQ-025 SHALL use a bit-index counter that counts DATA_W payload bits exactly; the DATA_W=1 boundary produces one payload bit.
REQ-026 SHALL register D; D is never driven combinationally from Data or Load.
REQ-027 SHALL never raise Done outside the single cycle after a completed stop bit.

Reset
REQ-028 SHALL, while Reset=1, immediately and regardless of Clock force: state IDLE, D=1, Ready=1, Busy=0, Done=0, counters 0, shift register 0.
REQ-029 SHALL, on Reset asserted mid-frame, abort the frame with no Done pulse; after release the first accepted Load starts a complete new frame.
REQ-030 SHALL ignore a Load asserted while Reset=1.

Verification
REQ-031 SHALL cover basic frame: defaults, Data=8'hA5, Load for one cycle -> D = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; Done pulses at accept+40 cycles.
REQ-032 SHALL cover parity: PARITY_EN=1, Data=8'h07 -> parity bit 1 and frame length 44 cycles; Data=8'h03 -> parity bit 0.
REQ-033 SHALL cover back-to-back: Load held high continuously with Data=8'h00 then 8'hFF -> two complete frames separated by exactly one idle-high cycle; the second Load is accepted only after Done.
REQ-034 SHALL cover busy-ignore: Load pulsed with Data=8'h3C at accept+10 cycles during a frame of 8'h81 -> only the 8'h81 frame is sent, with one Done.
REQ-035 SHALL cover reset mid-frame: Reset asserted asynchronously (not on an edge) at accept+17 cycles -> D=1 and Ready=1 before the next edge, with no Done; then 8'h5A sends a correct frame.
REQ-036 SHALL cover the minimum period: CLKS_PER_BIT=1, DATA_W=1, Data=1'b1 -> D = 0,1,1 over 3 cycles, then Done.

Source files
------------

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - parameterised serial transmitter with optional even parity
//
// Purpose:
//   Takes a parallel word on a Load handshake and sends it on D as one frame:
//   a start bit (0), the payload LSB first, an optional even-parity bit and a
//   stop bit (1). Each bit is held for CLKS_PER_BIT clocks. D idles high.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (1..255)
//   DATA_W        payload bits per frame (1..16)
//   PARITY_EN     1 inserts an even-parity bit after the payload
//
// Ports:
//   Clock  in   rising-edge clock
//   Reset  in   asynchronous active-high reset
//   Data   in   word to send, captured when a Load is accepted
//   Load   in   send request, accepted only while Ready=1
//   Ready  out  high in IDLE (a Load will be accepted)
//   D      out  registered serial line, idle-high
//   Busy   out  inverse of Ready
//   Done   out  one-cycle pulse in the cycle after the stop bit ends

module serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8,
    parameter int PARITY_EN    = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Data,
    input  logic              Load,
    output logic              Ready,
    output logic              D,
    output logic              Busy,
    output logic              Done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic              r_d;
    logic              r_done;

    state_t            w_state_nx;
    logic [CW-1:0]     w_cnt_nx;
    logic [IW-1:0]     w_idx_nx;
    logic [DATA_W-1:0] w_shift_nx;
    logic              w_par_nx;
    logic              w_d_nx;
    logic              w_done_nx;
    logic              w_bit_end;
    logic [DATA_W-1:0] w_shift_dn;

    assign w_bit_end  = (r_cnt == CNT_MAX);
    assign w_shift_dn = r_shift >> 1;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_d     <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_par   <= w_par_nx;
            r_d     <= w_d_nx;
            r_done  <= w_done_nx;
        end
    end

    // D is computed one cycle ahead so that the registered line changes on
    // the same edge the FSM moves into the bit it belongs to.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_par_nx   = r_par;
        w_d_nx     = r_d;
        w_done_nx  = 1'b0;

        case (r_state)
            IDLE: begin
                w_d_nx = 1'b1;
                if (Load) begin
                    w_state_nx = START;
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                    w_shift_nx = Data;
                    w_par_nx   = ^Data;
                    w_d_nx     = 1'b0;
                end
            end

            START: begin
                if (w_bit_end) begin
                    w_state_nx = DATA;
                    w_cnt_nx   = '0;
                    w_d_nx     = r_shift[0];
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end

            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nx = '0;
                    if (r_idx == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            w_state_nx = PARITY;
                            w_d_nx     = r_par;
                        end else begin
                            w_state_nx = STOP;
                            w_d_nx     = 1'b1;
                        end
                    end else begin
                        w_idx_nx   = r_idx + IW'(1);
                        w_shift_nx = w_shift_dn;
                        w_d_nx     = w_shift_dn[0];
                    end
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end

            PARITY: begin
                if (w_bit_end) begin
                    w_state_nx = STOP;
                    w_cnt_nx   = '0;
                    w_d_nx     = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end

            STOP: begin
                if (w_bit_end) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                    w_d_nx     = 1'b1;
                    w_done_nx  = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end

            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
                w_d_nx     = 1'b1;
            end
        endcase
    end

    assign Ready = (r_state == IDLE);
    assign Busy  = ~Ready;
    assign D     = r_d;
    assign Done  = r_done;

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - self-checking bench for serial_tx (three parameter sets)
module tb_serial_tx;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [2:0] load;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       data2;
    logic [2:0] d_o;
    logic [2:0] ready_o;
    logic [2:0] busy_o;
    logic [2:0] done_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clock = ~Clock;

    // inst 0: defaults; inst 1: parity; inst 2: minimum period and width
    serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(0)) u_dut0 (
        .Clock(Clock), .Reset(Reset), .Data(data0), .Load(load[0]),
        .Ready(ready_o[0]), .D(d_o[0]), .Busy(busy_o[0]), .Done(done_o[0]));
    serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .Data(data1), .Load(load[1]),
        .Ready(ready_o[1]), .D(d_o[1]), .Busy(busy_o[1]), .Done(done_o[1]));
    serial_tx #(.CLKS_PER_BIT(1), .DATA_W(1), .PARITY_EN(0)) u_dut2 (
        .Clock(Clock), .Reset(Reset), .Data(data2), .Load(load[2]),
        .Ready(ready_o[2]), .D(d_o[2]), .Busy(busy_o[2]), .Done(done_o[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: a list of frame bits plus a position in cycles.
    int cp [3] = '{4, 4, 1};
    int wd [3] = '{8, 8, 1};
    int pe [3] = '{0, 1, 0};
    int m_rem [3] = '{0, 0, 0};
    int m_pos [3] = '{0, 0, 0};
    bit m_done [3] = '{1'b0, 1'b0, 1'b0};
    bit fb [3][20];

    function automatic logic [15:0] data_of(input int i);
        case (i)
            0:       return {8'h00, data0};
            1:       return {8'h00, data1};
            default: return {15'h0000, data2};
        endcase
    endfunction

    always @(posedge Clock or posedge Reset) begin
        logic [15:0] w;
        int n;
        for (int i = 0; i < 3; i++) begin
            m_done[i] = 1'b0;
            if (Reset) begin
                m_rem[i] = 0;
                m_pos[i] = 0;
            end else if (m_rem[i] > 0) begin
                m_rem[i]--;
                m_pos[i]++;
                if (m_rem[i] == 0) m_done[i] = 1'b1;
            end else if (load[i]) begin
                w = data_of(i);
                n = 2 + wd[i] + pe[i];
                fb[i][0] = 1'b0;
                for (int b = 0; b < wd[i]; b++) fb[i][1 + b] = w[b];
                if (pe[i] != 0) fb[i][1 + wd[i]] = ^w;
                fb[i][n - 1] = 1'b1;
                m_rem[i] = n * cp[i];
                m_pos[i] = 0;
            end
        end
    end

    always @(negedge Clock) begin
        for (int i = 0; i < 3; i++) begin
            logic exp_d;
            exp_d = (m_rem[i] > 0) ? fb[i][m_pos[i] / cp[i]] : 1'b1;
            check($sformatf("u%0d_D", i),     32'(d_o[i]),     32'(exp_d));
            check($sformatf("u%0d_Ready", i), 32'(ready_o[i]), 32'(m_rem[i] == 0));
            check($sformatf("u%0d_Busy", i),  32'(busy_o[i]),  32'(m_rem[i] != 0));
            check($sformatf("u%0d_Done", i),  32'(done_o[i]),  32'(m_done[i]));
        end
    end

    task automatic pulse(input int i);
        load[i] = 1'b1;
        @(posedge Clock);
        #2;
        load[i] = 1'b0;
    endtask

    // j counts falling edges after the accept edge; bit b is sampled at j = b*C.
    task automatic capture(input int i, input int n, output logic [19:0] bits,
                           output int done_at, output int n_done);
        bits    = '0;
        done_at = -1;
        n_done  = 0;
        for (int j = 0; j < n * cp[i] + 6; j++) begin
            @(negedge Clock);
            if ((j % cp[i]) == 0 && (j / cp[i]) < n) bits[j / cp[i]] = d_o[i];
            if (done_o[i]) begin
                n_done++;
                if (done_at < 0) done_at = j;
            end
        end
    endtask

    logic [19:0] bits;
    int          da;
    int          nd;
    logic        dd  [96];
    logic        rdy [96];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        load  = 3'b000;
        data0 = 8'h00;
        data1 = 8'h00;
        data2 = 1'b0;
        repeat (2) @(negedge Clock);
        check("rst_D",     32'(d_o),     32'h7);
        check("rst_Ready", 32'(ready_o), 32'h7);
        check("rst_Busy",  32'(busy_o),  32'h0);
        check("rst_Done",  32'(done_o),  32'h0);
        load = 3'b111;
        @(negedge Clock);
        check("rst_load_ignored", 32'(ready_o), 32'h7);
        load = 3'b000;
        @(posedge Clock);
        #2;
        Reset = 1'b0;

        // basic frame
        data0 = 8'hA5;
        pulse(0);
        capture(0, 10, bits, da, nd);
        check("a5_bits",   32'(bits[9:0]), 32'(10'b1101001010));
        check("a5_done_at", 32'(da), 32'd40);
        check("a5_n_done",  32'(nd), 32'd1);

        // parity
        data1 = 8'h07;
        pulse(1);
        capture(1, 11, bits, da, nd);
        check("p07_par",     32'(bits[9]), 32'd1);
        check("p07_done_at", 32'(da), 32'd44);
        data1 = 8'h03;
        pulse(1);
        capture(1, 11, bits, da, nd);
        check("p03_par",   32'(bits[9]), 32'd0);
        check("p03_frame", 32'(bits[10:0]), 32'(11'b10000000110));

        // back-to-back with Load held; Data changes after capture
        data0   = 8'h00;
        load[0] = 1'b1;
        @(posedge Clock);
        #2;
        data0 = 8'hFF;
        for (int j = 0; j < 96; j++) begin
            @(negedge Clock);
            dd[j]  = d_o[0];
            rdy[j] = ready_o[0];
            if (j == 41) load[0] = 1'b0;
        end
        check("b2b_bit0_held", 32'(dd[4]),   32'd0);
        check("b2b_stop",      32'(dd[39]),  32'd1);
        check("b2b_gap_D",     32'(dd[40]),  32'd1);
        check("b2b_gap_Ready", 32'(rdy[40]), 32'd1);
        check("b2b_start2",    32'(dd[41]),  32'd0);
        check("b2b_busy2",     32'(rdy[41]), 32'd0);
        check("b2b_ff_bit0",   32'(dd[45]),  32'd1);
        check("b2b_idle_end",  32'(rdy[82]), 32'd1);

        // Load ignored while busy
        data0 = 8'h81;
        pulse(0);
        bits = '0;
        nd   = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge Clock);
            if (j == 9) begin
                data0   = 8'h3C;
                load[0] = 1'b1;
            end
            if (j == 10) load[0] = 1'b0;
            if ((j % 4) == 0 && j < 40) bits[j / 4] = d_o[0];
            if (done_o[0]) nd++;
        end
        check("ign_bits",   32'(bits[9:0]), 32'(10'b1100000010));
        check("ign_n_done", 32'(nd), 32'd1);

        // asynchronous reset mid-frame
        data0 = 8'h5A;
        pulse(0);
        repeat (17) @(posedge Clock);
        #3;
        Reset = 1'b1;
        #1;
        check("arst_D",     32'(d_o[0]),     32'd1);
        check("arst_Ready", 32'(ready_o[0]), 32'd1);
        check("arst_Done",  32'(done_o[0]),  32'd0);
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        data0 = 8'h5A;
        pulse(0);
        capture(0, 10, bits, da, nd);
        check("r5a_bits",    32'(bits[9:0]), 32'(10'b1010110100));
        check("r5a_done_at", 32'(da), 32'd40);
        check("r5a_n_done",  32'(nd), 32'd1);

        // minimum period and width
        data2 = 1'b1;
        pulse(2);
        capture(2, 3, bits, da, nd);
        check("min_bits",    32'(bits[2:0]), 32'(3'b110));
        check("min_done_at", 32'(da), 32'd3);
        check("min_n_done",  32'(nd), 32'd1);

        repeat (2) @(negedge Clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
